// File: rtl/ysyx_25040109_mdu_seq.sv
// Sequential RV32M multiply/divide unit.
// Shift-add multiply and restoring divide, one step per cycle, on a 2*WIDTH accumulator.
// Division corner cases (zero divisor, signed overflow) are resolved at accept time.
module ysyx_25040109_mdu_seq #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       funct3,
  input  logic [WIDTH-1:0] src1,
  input  logic [WIDTH-1:0] src2,
  input  logic [4:0]       rd_addr,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [4:0]       rd_addr_out,
  output logic             busy
);

  localparam int unsigned AccW = 2 * WIDTH;

  typedef enum logic [1:0] {StIdle, StCalc, StDone} state_e;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [2:0]        op_q, op_d;
  logic [4:0]        rd_q, rd_d;
  logic [AccW-1:0]   acc_q, acc_d;
  // Multiplicand magnitude for multiply, divisor magnitude for divide.
  logic [WIDTH-1:0]  opnd_q, opnd_d;
  // Product / quotient sign and remainder sign.
  logic              neg_q_q, neg_q_d;
  logic              neg_r_q, neg_r_d;
  logic [WIDTH-1:0]  result_q, result_d;
  logic [4:0]        rd_out_q, rd_out_d;
  logic              out_valid_q, out_valid_d;

  // Accept-time operand decode.
  logic             op_div;
  logic             s1_signed, s2_signed;
  logic             neg1, neg2;
  logic [WIDTH-1:0] mag1, mag2;
  logic             div_by_zero, div_ovf, special;
  logic [WIDTH-1:0] special_res;

  // Iteration datapath.
  logic [WIDTH:0]   mul_sum;
  logic [AccW-1:0]  mul_next;
  logic [WIDTH:0]   div_part;
  logic [WIDTH:0]   div_diff;
  logic             div_ge;
  logic [AccW-1:0]  div_next;

  // Finalisation.
  logic [AccW-1:0]  prod;
  logic [WIDTH-1:0] quo_f, rem_f;
  logic [WIDTH-1:0] final_res;

  assign op_div    = funct3[2];
  // MULH, MULHSU, DIV, REM treat src1 as signed; MULH, DIV, REM treat src2 as signed.
  assign s1_signed = (funct3 == 3'b001) || (funct3 == 3'b010) ||
                     (funct3 == 3'b100) || (funct3 == 3'b110);
  assign s2_signed = (funct3 == 3'b001) || (funct3 == 3'b100) || (funct3 == 3'b110);
  assign neg1      = s1_signed & src1[WIDTH-1];
  assign neg2      = s2_signed & src2[WIDTH-1];
  // The most negative value maps onto itself, which is the correct unsigned magnitude.
  assign mag1      = neg1 ? -src1 : src1;
  assign mag2      = neg2 ? -src2 : src2;

  assign div_by_zero = op_div && (src2 == '0);
  assign div_ovf     = op_div && !funct3[0] &&
                       (src1 == {1'b1, {(WIDTH-1){1'b0}}}) && (src2 == '1);
  assign special     = div_by_zero || div_ovf;
  // Zero divisor: quotient all ones, remainder is the dividend.
  // Overflow: quotient is the dividend (most negative), remainder zero.
  assign special_res = div_by_zero ? (funct3[1] ? src1 : '1)
                                   : (funct3[1] ? '0 : src1);

  // Shift-add step: conditionally add the multiplicand into the high half, shift right.
  assign mul_sum  = {1'b0, acc_q[AccW-1:WIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
  assign mul_next = {mul_sum, acc_q[WIDTH-1:1]};

  // Restoring step: shift the remainder/quotient pair left, trial-subtract the divisor.
  // A set MSB in the difference is a borrow, i.e. the partial remainder was smaller.
  assign div_part = acc_q[AccW-1:WIDTH-1];
  assign div_diff = div_part - {1'b0, opnd_q};
  assign div_ge   = ~div_diff[WIDTH];
  assign div_next = {(div_ge ? div_diff[WIDTH-1:0] : div_part[WIDTH-1:0]),
                     acc_q[WIDTH-2:0], div_ge};

  assign prod  = neg_q_q ? -acc_q : acc_q;
  assign quo_f = neg_q_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
  assign rem_f = neg_r_q ? -acc_q[AccW-1:WIDTH] : acc_q[AccW-1:WIDTH];

  // Select the architectural result for the latched operation.
  always_comb begin
    final_res = '0;
    case (op_q)
      3'b000:                 final_res = prod[WIDTH-1:0];
      3'b001, 3'b010, 3'b011: final_res = prod[AccW-1:WIDTH];
      3'b100, 3'b101:         final_res = quo_f;
      default:                final_res = rem_f;
    endcase
  end

  // Next-state and datapath update; flush overrides every other transition.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    op_d        = op_q;
    rd_d        = rd_q;
    acc_d       = acc_q;
    opnd_d      = opnd_q;
    neg_q_d     = neg_q_q;
    neg_r_d     = neg_r_q;
    result_d    = result_q;
    rd_out_d    = rd_out_q;
    out_valid_d = out_valid_q;

    if (flush) begin
      state_d     = StIdle;
      cnt_d       = '0;
      out_valid_d = 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          if (in_valid) begin
            op_d    = funct3;
            rd_d    = rd_addr;
            neg_q_d = neg1 ^ neg2;
            neg_r_d = neg1;
            cnt_d   = '0;
            if (special) begin
              result_d    = special_res;
              rd_out_d    = rd_addr;
              out_valid_d = 1'b1;
              state_d     = StDone;
            end else begin
              // Multiply: low half holds the multiplier. Divide: low half holds the dividend.
              acc_d   = {{WIDTH{1'b0}}, (op_div ? mag1 : mag2)};
              opnd_d  = op_div ? mag2 : mag1;
              state_d = StCalc;
            end
          end
        end
        StCalc: begin
          // Counts 0..WIDTH-1 iterate; the cycle after the last step applies signs.
          if (cnt_q == CNT_W'(WIDTH)) begin
            result_d    = final_res;
            rd_out_d    = rd_q;
            out_valid_d = 1'b1;
            cnt_d       = '0;
            state_d     = StDone;
          end else begin
            acc_d = op_q[2] ? div_next : mul_next;
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        StDone: begin
          if (out_ready) begin
            out_valid_d = 1'b0;
            state_d     = StIdle;
          end
        end
        default: begin
          state_d     = StIdle;
          out_valid_d = 1'b0;
        end
      endcase
    end
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      op_q        <= '0;
      rd_q        <= '0;
      acc_q       <= '0;
      opnd_q      <= '0;
      neg_q_q     <= 1'b0;
      neg_r_q     <= 1'b0;
      result_q    <= '0;
      rd_out_q    <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      op_q        <= op_d;
      rd_q        <= rd_d;
      acc_q       <= acc_d;
      opnd_q      <= opnd_d;
      neg_q_q     <= neg_q_d;
      neg_r_q     <= neg_r_d;
      result_q    <= result_d;
      rd_out_q    <= rd_out_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready    = (state_q == StIdle);
  assign busy        = (state_q != StIdle);
  assign out_valid   = out_valid_q;
  assign result      = result_q;
  assign rd_addr_out = rd_out_q;

endmodule

// File: tb/tb_ysyx_25040109_mdu_seq.sv
// Bench for the sequential multiply/divide unit: directed vectors with literal
// expectations, plus a per-cycle monitor driven by an arithmetic reference model.
module tb_ysyx_25040109_mdu_seq;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        flush = 1'b0;
  logic        out_ready = 1'b0;
  logic [2:0]  funct3 = '0;
  logic [31:0] src1 = '0;
  logic [31:0] src2 = '0;
  logic [4:0]  rd_addr = '0;
  logic        in_ready, out_valid, busy;
  logic [31:0] result;
  logic [4:0]  rd_addr_out;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  ysyx_25040109_mdu_seq #(
    .WIDTH(32),
    .CNT_W(6)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .funct3     (funct3),
    .src1       (src1),
    .src2       (src2),
    .rd_addr    (rd_addr),
    .flush      (flush),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .result     (result),
    .rd_addr_out(rd_addr_out),
    .busy       (busy)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: RV32M semantics computed with wide integer arithmetic.
  function automatic logic [31:0] ref_op(input logic [2:0] f, input logic [31:0] a,
                                         input logic [31:0] b);
    longint      sa, sb, ub;
    logic [63:0] ua64, ub64, p;
    int          q;
    sa   = longint'($signed(a));
    sb   = longint'($signed(b));
    ub   = longint'({32'b0, b});
    ua64 = {32'b0, a};
    ub64 = {32'b0, b};
    p    = '0;
    q    = 0;
    case (f)
      3'd0: begin p = ua64 * ub64; return p[31:0]; end
      3'd1: begin p = sa * sb;     return p[63:32]; end
      3'd2: begin p = sa * ub;     return p[63:32]; end
      3'd3: begin p = ua64 * ub64; return p[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
        q = $signed(a) / $signed(b);
        return q;
      end
      3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: begin
        if (b == 0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
        q = $signed(a) % $signed(b);
        return q;
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic bit is_special(input logic [2:0] f, input logic [31:0] a,
                                    input logic [31:0] b);
    return f[2] && ((b == 0) || (!f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF));
  endfunction

  // Monitor: tracks the expected transaction and checks all outputs every cycle.
  bit          m_live = 1'b0;
  bit          m_pend = 1'b0;
  int          m_k = 0;
  int          m_lat = 0;
  logic [31:0] m_res = '0;
  logic [4:0]  m_rd = '0;

  always @(negedge clk) begin
    bit mv;
    if (m_live) begin
      if (m_pend) m_k++;
      mv = m_pend && (m_k >= m_lat);
      chk("mon_out_valid", 32'(out_valid), 32'(mv));
      chk("mon_busy", 32'(busy), 32'(m_pend));
      chk("mon_in_ready", 32'(in_ready), 32'(!m_pend));
      if (mv) begin
        chk("mon_result", result, m_res);
        chk("mon_rd", 32'(rd_addr_out), 32'(m_rd));
      end
    end
    // Events taking effect at the coming rising edge.
    if (rst) begin
      m_live = 1'b1;
      m_pend = 1'b0;
    end else if (m_live) begin
      if (flush) begin
        m_pend = 1'b0;
      end else if (!m_pend && in_valid) begin
        m_pend = 1'b1;
        m_k    = -1;
        m_res  = ref_op(funct3, src1, src2);
        m_rd   = rd_addr;
        m_lat  = is_special(funct3, src1, src2) ? 0 : 33;
      end else if (m_pend && (m_k >= m_lat) && out_ready) begin
        m_pend = 1'b0;
      end
    end
  end

  // Called 1 time unit after a rising edge with the unit idle.
  // lat counts rising edges after the accept edge until out_valid is visible.
  task automatic run_op(input string name, input logic [2:0] f, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] rd, input logic [31:0] lit,
                        input int lat, input int hold);
    int n;
    in_valid  = 1'b1;
    funct3    = f;
    src1      = a;
    src2      = b;
    rd_addr   = rd;
    out_ready = (hold == 0);
    chk({name, "_in_ready"}, 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    funct3   = 3'($urandom);
    src1     = $urandom;
    src2     = $urandom;
    rd_addr  = 5'($urandom);
    n = 0;
    while (!out_valid && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    chk({name, "_latency"}, 32'(n), 32'(lat));
    chk({name, "_result"}, result, lit);
    chk({name, "_rd"}, 32'(rd_addr_out), 32'(rd));
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      chk({name, "_hold_valid"}, 32'(out_valid), 32'd1);
      chk({name, "_hold_result"}, result, lit);
      chk({name, "_hold_rd"}, 32'(rd_addr_out), 32'(rd));
      chk({name, "_hold_in_ready"}, 32'(in_ready), 32'd0);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk({name, "_taken_valid"}, 32'(out_valid), 32'd0);
    chk({name, "_taken_in_ready"}, 32'(in_ready), 32'd1);
  endtask

  initial begin
    bit seen;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("reset_out_valid", 32'(out_valid), 32'd0);
    chk("reset_result", result, 32'd0);
    chk("reset_rd", 32'(rd_addr_out), 32'd0);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_in_ready", 32'(in_ready), 32'd1);

    run_op("mul",    3'd0, 32'd7,         32'hFFFF_FFFD, 5'd3,  32'hFFFF_FFEB, 33, 0);
    run_op("mulh",   3'd1, 32'h8000_0000, 32'hFFFF_FFFF, 5'd4,  32'h0000_0000, 33, 0);
    run_op("mulhsu", 3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 5'd5,  32'h8000_0000, 33, 0);
    run_op("mulhu",  3'd3, 32'h8000_0000, 32'hFFFF_FFFF, 5'd6,  32'h7FFF_FFFF, 33, 0);
    run_op("div",    3'd4, 32'hFFFF_FFF9, 32'd2,         5'd7,  32'hFFFF_FFFD, 33, 0);
    run_op("rem",    3'd6, 32'hFFFF_FFF9, 32'd2,         5'd8,  32'hFFFF_FFFF, 33, 0);
    run_op("divu",   3'd5, 32'd100,       32'd7,         5'd9,  32'd14,        33, 0);
    run_op("remu",   3'd7, 32'd100,       32'd7,         5'd10, 32'd2,         33, 0);
    run_op("divu0",  3'd5, 32'd5,         32'd0,         5'd11, 32'hFFFF_FFFF, 0,  0);
    run_op("rem0",   3'd6, 32'd5,         32'd0,         5'd12, 32'd5,         0,  0);
    run_op("divovf", 3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 5'd13, 32'h8000_0000, 0,  0);
    run_op("removf", 3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 5'd14, 32'h0,         0,  0);
    // Back-pressure, then an immediate back-to-back accept.
    run_op("bp_mul", 3'd0, 32'h0001_2345, 32'h10,        5'd15, 32'h0012_3450, 33, 10);
    run_op("bp_next",3'd7, 32'd1000,      32'd33,        5'd16, 32'd10,        33, 0);

    // Flush in CALC iteration 15.
    in_valid = 1'b1; funct3 = 3'd0; src1 = 32'd3; src2 = 32'd5; rd_addr = 5'd17;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (15) @(posedge clk);
    #1;
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    chk("flush_busy", 32'(busy), 32'd0);
    chk("flush_in_ready", 32'(in_ready), 32'd1);
    chk("flush_out_valid", 32'(out_valid), 32'd0);
    seen = 1'b0;
    repeat (40) begin
      @(posedge clk); #1;
      if (out_valid) seen = 1'b1;
    end
    chk("flush_never_valid", 32'(seen), 32'd0);

    // Flush together with in_valid: not accepted.
    in_valid = 1'b1; flush = 1'b1; funct3 = 3'd5; src1 = 32'd9; src2 = 32'd0;
    @(posedge clk); #1;
    in_valid = 1'b0; flush = 1'b0;
    chk("flush_acc_busy", 32'(busy), 32'd0);
    chk("flush_acc_valid", 32'(out_valid), 32'd0);

    // Flush while a result waits, with out_ready in the same cycle.
    in_valid = 1'b1; funct3 = 3'd5; src1 = 32'd5; src2 = 32'd0; rd_addr = 5'd18;
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("done_flush_pre_valid", 32'(out_valid), 32'd1);
    flush = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0; out_ready = 1'b0;
    chk("done_flush_valid", 32'(out_valid), 32'd0);
    chk("done_flush_in_ready", 32'(in_ready), 32'd1);

    // Reset mid-CALC.
    in_valid = 1'b1; funct3 = 3'd1; src1 = 32'h1234_5678; src2 = 32'h9ABC_DEF0; rd_addr = 5'd19;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_result", result, 32'd0);
    chk("rst_rd", 32'(rd_addr_out), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);

    run_op("post_rst", 3'd3, 32'h0001_0000, 32'h0001_0000, 5'd31, 32'h1, 33, 0);

    repeat (3) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #200000;
    n_err++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
